axis_divider: RTL and testbench

AXIS_DIVIDER -- requirements
Module: axis_divider

---
 rtl/cpu_defs_pkg.sv | 7 +
 rtl/axis_divider.sv | 74 +++++++
 tb/tb_axis_divider.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared CPU type definitions and divider constants.
package cpu_defs_pkg;
  typedef logic [31:0] uint32_t;
  typedef logic [63:0] uint64_t;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/axis_divider.sv
// axis_divider: 32-bit restoring divider with AXI-Stream operand/result ports.
module axis_divider
  import cpu_defs_pkg::*;
#(
  parameter bit SIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata
);
  div_state_t state, state_nxt;
  logic [4:0] cnt;
  uint32_t mag_a, mag_b, quot, rem;
  logic q_neg, r_neg, accept, sign_a, sign_b, fits;
  logic [DIV_WIDTH:0] trial, diff;
  assign accept = state == IDLE && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
  assign sign_a = SIGNED && s_axis_dividend_tdata[31];
  assign sign_b = SIGNED && s_axis_divisor_tdata[31];
  assign s_axis_dividend_tready = state == IDLE;
  assign s_axis_divisor_tready = state == IDLE;
  assign m_axis_dout_tvalid = state == DONE;
  // partial remainders never reach 2^32, so bit 32 of diff is a clean borrow
  assign trial = {rem, mag_a[cnt]};
  assign diff = trial - {1'b0, mag_b};
  assign fits = !diff[DIV_WIDTH];
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = accept ? CALC : IDLE;
      CALC: state_nxt = cnt == 5'd0 ? FIX : CALC;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // divide-by-zero keeps the all-ones quotient unsigned so it survives the fix step
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 5'd0;
      mag_a <= '0;
      mag_b <= '0;
      quot <= '0;
      rem <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      m_axis_dout_tdata <= '0;
    end else if (accept) begin
      cnt <= 5'd31;
      mag_a <= sign_a ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
      mag_b <= sign_b ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
      quot <= '0;
      rem <= '0;
      q_neg <= (sign_a ^ sign_b) && s_axis_divisor_tdata != '0;
      r_neg <= sign_a;
    end else if (state == CALC) begin
      cnt <= cnt == 5'd0 ? cnt : cnt - 5'd1;
      quot[cnt] <= fits;
      rem <= fits ? diff[31:0] : trial[31:0];
    end else if (state == FIX) begin
      m_axis_dout_tdata <= {q_neg ? -quot : quot, r_neg ? -rem : rem};
    end
  end
endmodule

// File: tb/tb_axis_divider.sv
// tb_axis_divider: directed checks of signed and unsigned dividers against a cycle-level model.
module tb_axis_divider;
  logic clk = 1'b0, rst = 1'b1;
  logic dvv = 1'b0, sv = 1'b0;
  logic [31:0] dd = '0, dv = '0;
  logic rdy_s, rdy_s2, rdy_u, rdy_u2, tv_s, tv_u;
  logic [63:0] td_s, td_u;
  int cyc = 0, vectors = 0, miscompares = 0;
  int ready_at = 0, due = 0;
  bit live = 0, pend = 0;
  logic [63:0] exp_s, exp_u;

  axis_divider #(.SIGNED(1)) u_div (
    .clk(clk), .reset(rst),
    .s_axis_dividend_tvalid(dvv), .s_axis_dividend_tready(rdy_s), .s_axis_dividend_tdata(dd),
    .s_axis_divisor_tvalid(sv), .s_axis_divisor_tready(rdy_s2), .s_axis_divisor_tdata(dv),
    .m_axis_dout_tvalid(tv_s), .m_axis_dout_tdata(td_s)
  );
  axis_divider #(.SIGNED(0)) u_divu (
    .clk(clk), .reset(rst),
    .s_axis_dividend_tvalid(dvv), .s_axis_dividend_tready(rdy_u), .s_axis_dividend_tdata(dd),
    .s_axis_divisor_tvalid(sv), .s_axis_divisor_tready(rdy_u2), .s_axis_divisor_tdata(dv),
    .m_axis_dout_tvalid(tv_u), .m_axis_dout_tdata(td_u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] mdl(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 0) return {32'hFFFFFFFF, a};
    if (!sgn) return {a / b, a % b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
    sa = a;
    sb = b;
    return {32'(sa / sb), 32'(sa % sb)};
  endfunction

  always @(negedge clk) begin
    if (live) begin
      chk("tready_s", {63'b0, rdy_s}, {63'b0, cyc >= ready_at});
      chk("tready_s_pair", {63'b0, rdy_s2}, {63'b0, cyc >= ready_at});
      chk("tready_u", {63'b0, rdy_u}, {63'b0, cyc >= ready_at});
      chk("tready_u_pair", {63'b0, rdy_u2}, {63'b0, cyc >= ready_at});
      chk("tvalid_s", {63'b0, tv_s}, {63'b0, pend && cyc == due});
      chk("tvalid_u", {63'b0, tv_u}, {63'b0, pend && cyc == due});
      if (pend && cyc == due) begin
        chk("tdata_s", td_s, exp_s);
        chk("tdata_u", td_u, exp_u);
        pend = 0;
      end
    end
    if (rst) begin
      live = 1;
      ready_at = cyc + 1;
      pend = 0;
    end else if (live && cyc >= ready_at && dvv && sv) begin
      pend = 1;
      due = cyc + 34;
      ready_at = cyc + 35;
      exp_s = mdl(1, dd, dv);
      exp_u = mdl(0, dd, dv);
    end
  end

  task automatic wait_ready(output int t);
    int n = 0;
    @(negedge clk);
    while (!rdy_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_s) chk("ready_timeout", 64'd0, 64'd1);
    t = cyc;
  endtask

  task automatic wait_result(input int t0, input int lat, input string name);
    int n = 0;
    @(negedge clk);
    while (!tv_s && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(cyc - t0), 64'(lat));
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] es, input logic [63:0] eu);
    int t0;
    @(posedge clk); #1;
    dd = a; dv = b; dvv = 1; sv = 1;
    wait_ready(t0);
    @(posedge clk); #1;
    dvv = 0; sv = $urandom_range(0, 1); dd = $urandom; dv = $urandom;
    wait_result(t0, 34, "latency");
    chk("lit_s", td_s, es);
    chk("lit_u", td_u, eu);
    sv = 0;
  endtask

  initial begin
    int t0, cnt;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_tready", {63'b0, rdy_s}, 64'd1);
    chk("rst_tvalid", {63'b0, tv_s | tv_u}, 64'd0);
    chk("rst_tdata_s", td_s, 64'd0);
    chk("rst_tdata_u", td_u, 64'd0);

    op(32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002);
    op(32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001);
    op(32'd5, 32'd0, 64'hFFFFFFFF_00000005, 64'hFFFFFFFF_00000005);
    op(32'hFFFFFFF9, 32'd0, 64'hFFFFFFFF_FFFFFFF9, 64'hFFFFFFFF_FFFFFFF9);
    op(32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 64'h00000000_80000000);
    op(32'hFFFFFF9C, 32'hFFFFFFF9, 64'h0000000E_FFFFFFFE, 64'h00000000_FFFFFF9C);

    // abort mid-CALC
    @(posedge clk); #1;
    dd = 32'd1234; dv = 32'd10; dvv = 1; sv = 1;
    wait_ready(t0);
    @(posedge clk); #1;
    dvv = 0; sv = 0;
    while (cyc < t0 + 10) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_ready_cycle", 64'(cyc - t0), 64'd11);
    chk("abort_ready", {63'b0, rdy_s & rdy_u}, 64'd1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      cnt += int'(tv_s) + int'(tv_u);
    end
    chk("abort_no_pulse", 64'(cnt), 64'd0);

    // back-to-back with both tvalid held high
    @(posedge clk); #1;
    dd = 32'd1000; dv = 32'hFFFFFFFD; dvv = 1; sv = 1;
    wait_ready(t0);
    wait_result(t0, 34, "b2b_first");
    chk("b2b_first_s", td_s, 64'hFFFFFEB3_00000001);
    wait_ready(cnt);
    chk("b2b_accept2", 64'(cnt - t0), 64'd35);
    wait_result(t0, 69, "b2b_second");
    chk("b2b_second_u", td_u, 64'h00000000_000003E8);
    @(posedge clk); #1;
    dvv = 0; sv = 0;

    // dividend alone must not be consumed
    @(posedge clk); #1;
    dd = 32'd77; dv = 32'd5; dvv = 1; sv = 0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      cnt += int'(tv_s) + int'(tv_u);
    end
    chk("lone_no_result", 64'(cnt), 64'd0);
    chk("lone_ready", {63'b0, rdy_s & rdy_u}, 64'd1);
    op(32'd77, 32'd5, 64'h0000000F_00000002, 64'h0000000F_00000002);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
